// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 access codes, FSM encoding
// and the default timeout sizing.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned LSU_TIMEOUT_CYCLES = 16;
    localparam int unsigned LSU_CNT_W          = $clog2(LSU_TIMEOUT_CYCLES);

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus with req/gnt/rvalid handshake.
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_mem_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: decodes load/store requests from the ALU, runs the data-memory
// handshake, stalls the core while busy and returns aligned, extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic        i_req_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_misaligned,
    output logic        o_illegal,
    output logic        o_bus_err,
    load_store_unit_if.master mem_bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;
    logic [31:0]      r_rdata;
    logic             r_rdata_valid;
    logic             r_bus_err;

    logic             w_idle_req;
    logic             w_legal;
    logic             w_mis;
    logic             w_start;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_data;

    // Request decode: only meaningful while IDLE; later input changes are ignored.
    always_comb begin
        w_idle_req = i_req_valid && (r_state == ST_IDLE);
        if (i_req_is_store) begin
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        end else begin
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                      (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
        end
        w_mis = (((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && i_addr[0]) ||
                ((i_funct3 == F3_W) && (i_addr[1:0] != 2'b00));
        w_start = w_idle_req && w_legal && !w_mis;
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        if (i_req_is_store) begin
            case (i_funct3)
                F3_B: begin
                    w_be    = 4'b0001 << i_addr[1:0];
                    w_wdata = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = i_wdata;
                end
            endcase
        end
    end

    assign w_timeout = ((r_state == ST_REQ) || (r_state == ST_WAIT)) &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_REQ;
            ST_REQ: begin
                if (w_timeout) begin
                    w_state_next = ST_DONE;
                end else if (mem_bus.mem_gnt) begin
                    w_state_next = ST_WAIT;
                end
            end
            // A response in the last allowed cycle still completes normally.
            ST_WAIT: if (mem_bus.mem_rvalid || w_timeout) w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .i_mem_rdata (mem_bus.mem_rdata),
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_addr_lo),
        .o_rdata     (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_be          <= 4'b0000;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_funct3      <= 3'b000;
            r_addr_lo     <= 2'b00;
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rdata_valid <= 1'b0;
            r_bus_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cnt     <= '0;
                        r_req     <= 1'b1;
                        r_we      <= i_req_is_store;
                        r_be      <= w_be;
                        r_addr    <= {i_addr[31:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_funct3  <= i_funct3;
                        r_addr_lo <= i_addr[1:0];
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else if (mem_bus.mem_gnt) begin
                        r_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mem_bus.mem_rvalid) begin
                        r_rdata       <= r_we ? 32'd0 : w_load_data;
                        r_rdata_valid <= !r_we;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stall       = (r_state == ST_REQ) || (r_state == ST_WAIT) || w_start;
    assign o_illegal     = w_idle_req && !w_legal;
    assign o_misaligned  = w_idle_req && w_legal && w_mis;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_bus_err     = r_bus_err;

    assign mem_bus.mem_req   = r_req;
    assign mem_bus.mem_we    = r_we;
    assign mem_bus.mem_be    = r_be;
    assign mem_bus.mem_addr  = r_addr;
    assign mem_bus.mem_wdata = r_wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits directly downstream of the ALU and replaces the direct ALU-to-data-memory connection of the single-cycle core.
- Takes the ALU effective address, rs2 data and funct3 for load/store instructions and drives a word-addressed data-memory bus with a req/gnt/rvalid handshake.
- Returns byte/half-aligned, sign- or zero-extended load data to the writeback mux.
- Stalls the core (PC and register-file write held) while a transaction is outstanding; flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16, number of cycles allowed in REQ plus WAIT before the access is aborted with bus_err.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  current instruction is a load or store (MemRead|MemWrite).
- req_is_store  in  1  1 = store, 0 = load.
- funct3  in  3  access size and sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- addr  in  32  byte effective address from the ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  hold PC and suppress RegWrite.
- rdata  out  32  extended load result.
- rdata_valid  out  1  rdata is valid this cycle.
- misaligned  out  1  one-cycle misalignment flag.
- illegal  out  1  one-cycle unsupported-funct3 flag.
- bus_err  out  1  one-cycle timeout flag.
- mem_req  out  1  bus request.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data or write acknowledge.
- mem_rdata  in  32  read word.

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset: state IDLE; every registered output is 0; timeout counter 0; stall 0.
- Reset mid-operation: immediate return to IDLE; mem_req drops asynchronously.
- IDLE, req_valid=1:
  - Decode funct3. Loads accept {000,001,010,100,101}; stores accept {000,001,010}; anything else asserts illegal.
  - Misaligned means: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - illegal or misaligned: pulse the flag combinationally, stall=0, no bus activity, rdata_valid=0, stay IDLE. Illegal takes priority over misaligned.
  - Otherwise: stall=1 combinationally. Latch mem_addr, mem_we, mem_be, mem_wdata, funct3 and addr[1:0]; set mem_req=1; go REQ.
- REQ: mem_req held high with stable fields until mem_gnt=1. On the gnt cycle, clear mem_req at the next edge and go WAIT.
- WAIT:
  - On mem_rvalid=1, register the extended load data into rdata (stores: rdata=0) and go DONE.
  - mem_rvalid is considered only in WAIT. In IDLE and REQ it is ignored, so gnt and rvalid cannot complete in the same cycle.
- DONE: stall=0 and rdata_valid=1 for loads, for exactly one cycle; the core commits this cycle. Next state is IDLE. rdata is held until the next transaction.
- stall is 1 in REQ and WAIT, and in IDLE when starting a valid access.
- Minimum latency is 3 stall cycles: IDLE, REQ with immediate gnt, WAIT with rvalid.
- req_valid or inputs changing after the IDLE latch: ignored.
- Timeout:
  - The counter increments every cycle in REQ or WAIT and resets on entering REQ.
  - When it reaches TIMEOUT_CYCLES-1 without completion: mem_req=0, go DONE with bus_err=1 and rdata_valid=0.
- Store lane rules:
  - sb: mem_be=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - sh: mem_be=addr[1]?4'b1100:4'b0011, mem_wdata={2{wdata[15:0]}}.
  - sw: mem_be=4'b1111, mem_wdata=wdata.
- Loads: mem_be=4'b1111, mem_we=0.
- Load extract:
  - lb/lbu take byte lane addr[1:0] of mem_rdata.
  - lh/lhu take halfword addr[1].
  - Sign-extend for 000/001; zero-extend for 100/101.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding (2 bits: IDLE=0, REQ=1, WAIT=2, DONE=3).
  - Timeout counter width, $clog2(TIMEOUT_CYCLES).
- One combinational sub-module, lsu_load_align: (mem_rdata, funct3, addr_lo) -> extended 32-bit result.

Test Plan:
- lw addr=0x40, gnt in REQ cycle, rvalid next cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x40, mem_be=1111, stall high for 3 cycles, DONE rdata=0xDEADBEEF, rdata_valid=1.
- lb addr=0x43, mem_rdata=0x80123456 -> rdata=0xFFFFFF80; repeat as lbu -> 0x00000080; lhu addr=0x42 -> 0x00008012.
- sh addr=0x2E, wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_addr=0x2C, mem_wdata=0xABCDABCD; ack via rvalid -> DONE, rdata_valid=0.
- lw addr=0x42 -> misaligned pulse 1 cycle, stall=0, mem_req never asserted; load with funct3=011 -> illegal pulse only.
- gnt delayed 3 cycles -> mem_req and fields stable throughout. Separately, gnt given but rvalid withheld -> bus_err after 16 total REQ+WAIT cycles, then IDLE.
- rst asserted in WAIT -> outputs 0 immediately; a later rvalid is ignored; a following lw completes normally.
